// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic pipeline register with a valid/ready handshake,
// a two-entry skid buffer, synchronous flush and a saturating stall counter.
// The main register is the head of the stage and drives out_data. The skid
// register absorbs the single beat in flight while in_ready falls.
module pipe_skid_stage #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             push;
  logic             pop;
  logic             stall_hit;
  logic             stall_sat;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = main_q;
  assign stall_hit = out_valid & ~out_ready;
  assign stall_sat = &stall_cnt;

  // Occupancy FSM; in_ready/out_valid/count are registered alongside the
  // state so no combinational ready path crosses the stage boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      count     <= 2'd0;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      // Data registers keep their contents; only occupancy is squashed.
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      count     <= 2'd0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            main_q    <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
            count     <= 2'd1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_q <= in_data;
          end else if (push) begin
            skid_q   <= in_data;
            state    <= TWO;
            in_ready <= 1'b0;
            count    <= 2'd2;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            count     <= 2'd0;
          end
        end
        TWO: begin
          if (pop) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
            count    <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          count     <= 2'd0;
        end
      endcase
    end
  end

  // Saturating count of stalled cycles; clear wins over increment, flush ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (stall_hit && !stall_sat) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
